// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: FSM states, pixel geometry, grayscale helper.
package img_pkg;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR, STEP_X, STEP_Y, DONE} state_t;

  localparam int BYTES_PER_PIXEL = 3;

  // Weighted 1/2/1 channel sum, scaled to 8 bits and inverted so ink becomes bright.
  function automatic logic [7:0] gray8(input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2);
    logic [9:0] sum;
    sum = {2'b00, c0} + {1'b0, c1, 1'b0} + {2'b00, c2};
    return 8'd255 - sum[9:2];
  endfunction

endpackage

// File: rtl/nn_stepper.sv
// One axis of the nearest-neighbour mapper: source coordinate (quotient) plus
// remainder, advanced by adding the box span and reduced one LIMIT per cycle.
module nn_stepper #(
  parameter int LIMIT = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] base,
  input  logic        add,
  input  logic [15:0] span,
  input  logic        sub,
  output logic [15:0] q,
  output logic        busy
);

  logic [15:0] q_reg;
  logic [15:0] r_reg;

  // Load restarts the axis; add/sub move the remainder, sub also bumps the coordinate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
      r_reg <= '0;
    end else if (load) begin
      q_reg <= base;
      r_reg <= '0;
    end else if (add) begin
      r_reg <= r_reg + span;
    end else if (sub) begin
      r_reg <= r_reg - 16'(LIMIT);
      q_reg <= q_reg + 16'd1;
    end
  end

  assign q    = q_reg;
  assign busy = (r_reg >= 16'(LIMIT));

endmodule

// File: rtl/crop_resample.sv
// Crops the reported bounding box out of a bottom-up 24-bit BMP memory, converts
// to inverted grayscale and nearest-neighbour resamples it to an OUT_W x OUT_H grid.
module crop_resample
  import img_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int OUT_W  = 28,
  parameter int OUT_H  = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  input  logic [15:0] xMin,
  input  logic [15:0] xMax,
  input  logic [15:0] yMin,
  input  logic [15:0] yMax,
  output logic [31:0] addr,
  input  logic [15:0] rddata,
  output logic [15:0] wraddr,
  output logic [7:0]  wrdata,
  output logic        wren
);

  state_t state_reg, state_next;

  logic [15:0] ox_reg, oy_reg, idx_reg;
  logic [15:0] bx0_reg, box_w_reg, box_h_reg;
  logic        empty_reg;
  logic [7:0]  c0_reg, c1_reg, pix_reg;
  logic [31:0] addr_hold_reg;

  logic [15:0] xmax_c, ymax_c, box_w_in, box_h_in;
  logic        box_empty, accept, last_pix, row_end;
  logic        x_load, x_add, x_sub, x_busy;
  logic        y_load, y_add, y_sub, y_busy;
  logic [15:0] x_base, sx, sy;
  logic [31:0] pix_addr;
  logic        unused_hi;

  assign unused_hi = ^rddata[15:8];

  // Box geometry from the raw inputs, with the far edges clamped into the image.
  always_comb begin
    xmax_c    = (xMax > 16'(WIDTH - 1))  ? 16'(WIDTH - 1)  : xMax;
    ymax_c    = (yMax > 16'(HEIGHT - 1)) ? 16'(HEIGHT - 1) : yMax;
    box_empty = (xMin > xmax_c) || (yMin > ymax_c);
    // A zero span keeps remainders at 0 so every step state lasts one cycle.
    box_w_in  = box_empty ? 16'd0 : (xmax_c - xMin + 16'd1);
    box_h_in  = box_empty ? 16'd0 : (ymax_c - yMin + 16'd1);
  end

  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_pix = (ox_reg == 16'(OUT_W - 1)) && (oy_reg == 16'(OUT_H - 1));
  assign row_end  = (ox_reg == 16'(OUT_W - 1));

  nn_stepper #(.LIMIT(OUT_W)) u_step_x (
    .clk(clk), .rst_n(rst_n), .load(x_load), .base(x_base), .add(x_add),
    .span(box_w_reg), .sub(x_sub), .q(sx), .busy(x_busy)
  );

  nn_stepper #(.LIMIT(OUT_H)) u_step_y (
    .clk(clk), .rst_n(rst_n), .load(y_load), .base(yMin), .add(y_add),
    .span(box_h_reg), .sub(y_sub), .q(sy), .busy(y_busy)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and stepper control.
  always_comb begin
    state_next = state_reg;
    x_load = 1'b0; x_add = 1'b0; x_sub = 1'b0;
    y_load = 1'b0; y_add = 1'b0; y_sub = 1'b0;
    x_base = bx0_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          x_load     = 1'b1;
          x_base     = xMin;
          y_load     = 1'b1;
          state_next = box_empty ? WR : RD0;
        end
      end
      RD0: state_next = RD1;
      RD1: state_next = RD2;
      RD2: state_next = WR;
      WR: begin
        if (last_pix) begin
          state_next = DONE;
        end else if (row_end) begin
          x_load     = 1'b1;
          y_add      = 1'b1;
          state_next = STEP_Y;
        end else begin
          x_add      = 1'b1;
          state_next = STEP_X;
        end
      end
      STEP_X: begin
        if (x_busy) x_sub = 1'b1;
        else        state_next = empty_reg ? WR : RD0;
      end
      STEP_Y: begin
        if (y_busy) y_sub = 1'b1;
        else        state_next = empty_reg ? WR : RD0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output-grid counters, latched box, channel capture and held address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ox_reg <= '0; oy_reg <= '0; idx_reg <= '0;
      bx0_reg <= '0; box_w_reg <= '0; box_h_reg <= '0; empty_reg <= 1'b0;
      c0_reg <= '0; c1_reg <= '0; pix_reg <= '0;
      addr_hold_reg <= '0;
    end else begin
      addr_hold_reg <= addr;
      if (accept) begin
        ox_reg    <= '0;
        oy_reg    <= '0;
        idx_reg   <= '0;
        bx0_reg   <= xMin;
        box_w_reg <= box_w_in;
        box_h_reg <= box_h_in;
        empty_reg <= box_empty;
      end
      if (state_reg == RD0) c0_reg  <= rddata[7:0];
      if (state_reg == RD1) c1_reg  <= rddata[7:0];
      if (state_reg == RD2) pix_reg <= gray8(c0_reg, c1_reg, rddata[7:0]);
      if ((state_reg == WR) && !last_pix) begin
        idx_reg <= idx_reg + 16'd1;
        if (row_end) begin
          ox_reg <= '0;
          oy_reg <= oy_reg + 16'd1;
        end else begin
          ox_reg <= ox_reg + 16'd1;
        end
      end
    end
  end

  // Byte address of the current source pixel; rows are stored bottom-up.
  always_comb begin
    pix_addr = (32'(HEIGHT - 1) - {16'd0, sy}) * 32'(WIDTH * BYTES_PER_PIXEL)
             + {16'd0, sx} * 32'(BYTES_PER_PIXEL);
    case (state_reg)
      RD0:     addr = pix_addr;
      RD1:     addr = pix_addr + 32'd1;
      RD2:     addr = pix_addr + 32'd2;
      default: addr = addr_hold_reg;
    endcase
  end

  assign done   = (state_reg == DONE);
  assign wren   = (state_reg == WR);
  assign wraddr = idx_reg;
  assign wrdata = (wren && !empty_reg) ? pix_reg : 8'd0;

endmodule

// File: doc/crop_resample.md
# crop_resample

Stage directly downstream of the bounding-box finder. Takes the box (xMin/xMax/yMin/yMax) it reports, re-reads that region from the same 24-bit bottom-up BMP pixel memory, and converts it to grayscale. Resamples the region by nearest neighbour to a fixed OUT_W × OUT_H grid and writes one inverted-intensity byte per output pixel into the classifier input buffer.

## Interface
- WIDTH, 100: source image width in pixels
- HEIGHT, 100: source image height in pixels
- OUT_W, 28: output grid width
- OUT_H, 28: output grid height
- Clock and reset: clk and rst_n. Reset is synchronous, active-low, on rst_n; the block is clocked by clk.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a frame (sampled in IDLE/DONE only)
- done  out  1  high while in DONE; buffer contents valid
- xMin, xMax, yMin, yMax  in  16 each  box in source pixel coords, sampled on accepted start
- addr  out  32  source byte address
- rddata  in  16  source byte; only [7:0] used; combinational (valid same cycle as addr)
- wraddr  out  16  output index = oy*OUT_W + ox
- wrdata  out  8  output pixel
- wren  out  1  one-cycle write strobe

## Operation
- Source address: addr = (HEIGHT-1-sy)*WIDTH*3 + sx*3 + c, with c ∈ {0,1,2}. No row padding.
- Box latch on accepted start:
  - bx0 = xMin, by0 = yMin.
  - xMax clamped to WIDTH-1, yMax clamped to HEIGHT-1.
  - boxW = xMax-xMin+1, boxH = yMax-yMin+1.
  - empty = (xMin > xMax) || (yMin > yMax).
- Mapping: sx = bx0 + floor(ox*boxW/OUT_W), sy = by0 + floor(oy*boxH/OUT_H). Computed incrementally with a quotient/remainder pair per axis; no divider.
- Gray = (c0 + 2*c1 + c2) >> 2, using a 10-bit sum. wrdata = 255 - gray. Ink becomes bright.
- Empty box: every output index is written with 0 and no reads are issued. Same state flow, with RD states skipped.
- States:
  - IDLE: wait for start; then ox=oy=0, rx=ry=0, sx=bx0, sy=by0, go to RD0 (or WR if empty).
  - RD0/RD1/RD2: present addr with c=0/1/2 and accumulate the channel (weight 1/2/1).
  - WR: wren=1 with wraddr/wrdata. If last pixel, go to DONE. Else if ox=OUT_W-1: ox=0, sx=bx0, rx=0, oy++, ry+=boxH, go to STEP_Y. Else ox++, rx+=boxW, go to STEP_X.
  - STEP_X / STEP_Y: while remainder ≥ OUT_W (resp. OUT_H), subtract it and increment sx (resp. sy), one subtraction per cycle. When it is below the limit, go to RD0 (WR if empty). Minimum 1 cycle.
  - DONE: done=1. start re-enters as from IDLE with fresh box inputs.
- start while busy is ignored.
- Remainders need at most 16 bits (< OUT + WIDTH).

## Timing
- Reset values: done=0, wren=0, addr=0, wraddr=0, wrdata=0. State is IDLE.
- start sampled at a rising edge in IDLE → RD0 is presented on the next cycle.
- Per output pixel: 3 read cycles + 1 WR cycle + (k+1) step cycles, where k = subtractions. Empty box: 1 WR + 1 step cycle.
- done rises the cycle after the final WR. It falls the cycle after an accepted start.
- Exactly OUT_W*OUT_H wren pulses per frame, wraddr strictly incrementing 0..OUT_W*OUT_H-1.
- rst_n low mid-frame: the next edge gives IDLE, wren=0 and done=0. The partial buffer is not cleared.

## Structure
- Package img_pkg holds:
  - state enum {IDLE, RD0, RD1, RD2, WR, STEP_X, STEP_Y, DONE}
  - BYTES_PER_PIXEL=3
  - a function gray8(c0,c1,c2) returning 255-((c0+2c1+c2)>>2)
- The same package is shared by the bounding-box finder for its address arithmetic.
- Sub-module nn_stepper: holds the quotient/remainder state for one axis (load base, add span, subtract limit, busy flag). It is instantiated twice, for x and y.

## Test plan
Memory model: combinational byte array; parameters at defaults unless noted.
- Identity: pixel(x,y) all channels = x+y; box (10,37,20,47) → out[oy*28+ox] = 225-ox-oy, 784 writes, then done=1.
- 2× downscale: same image; box (0,55,0,55) → out = 255-2ox-2oy.
- Upscale: same image; box (5,18,5,18) → out = 245-floor(ox/2)-floor(oy/2).
- Weighting: uniform c0=0, c1=100, c2=200; box (0,99,0,99) → every out = 155.
- Empty box: xMin=99, xMax=0 (bounding-box "no ink" result) → 784 writes of 0, exactly 2 cycles apart, and addr never changes from its reset value.
- Reset mid-frame: assert rst_n=0 after the 100th write → wren=0 and done=0 on the next edge. A following start completes a full 784-write frame. start pulsed during busy has no effect.
